mio_responder: RTL and testbench

Bus-side responder for the SCPU memory/IO interface: accepts CPU requests (`CPU_MIO`, `mem_w`, `Addr_out`, `Data_out`), serves them from an internal word RAM or a small peripheral register window after a programmable number of wait states, and completes each access with a one-cycle `MIO_ready` pulse and registered read data on `Data_in`. It sits between the CPU and the rest of the system. It replaces the fixed-latency memory model so the CPU's `MIO_ready` stall path is exercised.

---
 rtl/mio_pkg.sv | 49 ++++
 rtl/mio_byte_ram.sv | 37 +++
 rtl/mio_responder.sv | 172 +++++++++++++++++
 tb/tb_mio_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mio_pkg
// Description : Shared types and constants for the SCPU memory/IO responder:
//               FSM state encoding, address-map region codes, peripheral
//               register offsets, StoreX size encodings and the byte-lane
//               write-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mio_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mio_state_t;

    // Address-map region codes, decoded on Addr_out[31:28]
    localparam logic [3:0] MIO_RAM_RGN    = 4'h0;
    localparam logic [3:0] MIO_PERIPH_RGN = 4'hE;

    // Peripheral window word offsets, decoded on Addr_out[3:2]
    localparam logic [1:0] MIO_OFF_LED     = 2'd0;
    localparam logic [1:0] MIO_OFF_CYCLE   = 2'd1;
    localparam logic [1:0] MIO_OFF_SCRATCH = 2'd2;
    localparam logic [1:0] MIO_OFF_NONE    = 2'd3;

    // StoreX write-size encodings
    localparam logic [1:0] STX_BYTE     = 2'b00;
    localparam logic [1:0] STX_HALF     = 2'b01;
    localparam logic [1:0] STX_WORD_ALT = 2'b10;
    localparam logic [1:0] STX_WORD     = 2'b11;

    // Byte-lane write mask for a store of the given size at byte offset off.
    // Halfword stores select the half by off[1]; off[0] is ignored.
    function automatic logic [3:0] mio_byte_mask(input logic [1:0] storex,
                                                 input logic [1:0] off);
        logic [3:0] mask;
        case (storex)
            STX_BYTE: mask = 4'b0001 << off;
            STX_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mio_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : mio_byte_ram
// Description : 2^ADDR_W x 32-bit word RAM with a 4-bit byte-write mask and a
//               synchronous read port sharing the same address. Contents are
//               not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mio_byte_ram
    import mio_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Masked byte-lane write and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/mio_responder.sv
`default_nettype none
// ============================================================================
// Module      : mio_responder
// Description : Bus-side responder for the SCPU memory/IO interface. Captures
//               a CPU request, inserts WAIT_CYCLES wait states, then completes
//               with a one-cycle MIO_ready pulse. Serves a word RAM (region 0)
//               and a peripheral window (region E: LED, cycle counter,
//               scratch). Optional macro MIO_ERR_EN adds the bus_err output
//               flagging decode errors.
// Revision    : 1.0 - initial release
// ============================================================================
module mio_responder
    import mio_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    input  logic [1:0]  StoreX,
    output logic        MIO_ready,
    output logic [31:0] Data_in,
    output logic [31:0] led_out
`ifdef MIO_ERR_EN
    ,
    output logic        bus_err
`endif
);

    mio_state_t  state;
    logic [3:0]  wait_cnt;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_we;
    logic [1:0]  req_storex;
    logic [31:0] cycle_cnt;
    logic [31:0] scratch;

    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic              is_ram;
    logic              is_per;
    logic [1:0]        per_off;
    logic              map_err;
    logic [31:0]       rdata;

    // Decode of the captured request
    assign is_ram  = (req_addr[31:28] == MIO_RAM_RGN);
    assign is_per  = (req_addr[31:28] == MIO_PERIPH_RGN);
    assign per_off = req_addr[3:2];
    assign map_err = !(is_ram || (is_per && (per_off != MIO_OFF_NONE)));

    // In IDLE the RAM is addressed straight from the bus so that its registered
    // read is already valid on the completing edge even with zero wait states.
    assign ram_addr = (state == ST_IDLE) ? Addr_out[ADDR_W+1:2]
                                         : req_addr[ADDR_W+1:2];
    assign ram_we   = (state == ST_RESP) && req_we && is_ram;
    assign ram_be   = mio_byte_mask(req_storex, req_addr[1:0]);

    mio_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (req_data),
        .rdata (ram_q)
    );

    // Read-data mux over RAM, peripheral registers and unmapped space
    always_comb begin
        rdata = 32'h0;
        if (is_ram) begin
            rdata = ram_q;
        end else if (is_per) begin
            case (per_off)
                MIO_OFF_LED:     rdata = led_out;
                MIO_OFF_CYCLE:   rdata = cycle_cnt;
                MIO_OFF_SCRATCH: rdata = scratch;
                default:         rdata = 32'h0;
            endcase
        end
    end

    // Free-running cycle counter; reads see the value before this edge's increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Request FSM: capture, wait-state countdown, completion with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            req_addr   <= 32'h0;
            req_data   <= 32'h0;
            req_we     <= 1'b0;
            req_storex <= STX_WORD;
            MIO_ready  <= 1'b0;
            Data_in    <= 32'h0;
            led_out    <= 32'h0;
            scratch    <= 32'h0;
        end else begin
            MIO_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CPU_MIO) begin
                        req_addr   <= Addr_out;
                        req_data   <= Data_out;
                        req_we     <= mem_w;
                        req_storex <= StoreX;
                        wait_cnt   <= 4'(WAIT_CYCLES);
                        state      <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    MIO_ready <= 1'b1;
                    state     <= ST_IDLE;
                    if (req_we) begin
                        // Peripheral registers always take the full word
                        if (is_per && (per_off == MIO_OFF_LED)) begin
                            led_out <= req_data;
                        end
                        if (is_per && (per_off == MIO_OFF_SCRATCH)) begin
                            scratch <= req_data;
                        end
                    end else begin
                        Data_in <= rdata;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MIO_ERR_EN
    // Decode-error pulse aligned with the MIO_ready pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= (state == ST_RESP) && map_err;
        end
    end
`else
    logic unused_map_err;
    assign unused_map_err = map_err;
`endif

    // Address bits between the RAM index and the region code are don't-care
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[27:ADDR_W+2];

endmodule
`default_nettype wire

// File: tb/tb_mio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mio_responder
// Description : Self-checking bench for mio_responder. A WAIT_CYCLES=2
//               instance runs a table of accesses plus counter and reset
//               sequences; a WAIT_CYCLES=0 instance runs back-to-back reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mio_responder;
    import mio_pkg::*;

    localparam int WAITS = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  stx;
        logic [31:0] exp_rd;
        logic [31:0] exp_led;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mio, we;
    logic [31:0] addr, wdata;
    logic [1:0]  stx;
    logic        ready;
    logic [31:0] din, led;

    logic        b_mio, b_we;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_stx;
    logic        b_ready;
    logic [31:0] b_din, b_led;

`ifdef MIO_ERR_EN
    logic err, b_err;
`endif

    mio_responder #(.ADDR_W(10), .WAIT_CYCLES(WAITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (mio),
        .mem_w     (we),
        .Addr_out  (addr),
        .Data_out  (wdata),
        .StoreX    (stx),
        .MIO_ready (ready),
        .Data_in   (din),
        .led_out   (led)
`ifdef MIO_ERR_EN
        ,
        .bus_err   (err)
`endif
    );

    mio_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (b_mio),
        .mem_w     (b_we),
        .Addr_out  (b_addr),
        .Data_out  (b_wdata),
        .StoreX    (b_stx),
        .MIO_ready (b_ready),
        .Data_in   (b_din),
        .led_out   (b_led)
`ifdef MIO_ERR_EN
        ,
        .bus_err   (b_err)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rd  = 32'h0;
    exp_t        sb_q[$];
    exp_t        bq[$];
    vec_t        tbl[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    // One access on the WAIT_CYCLES=2 instance; expectation queued at drive time
    task automatic access(input vec_t v, input bit chk, input string tag,
                          output logic [31:0] got);
        exp_t e;
        int   cyc;
        e.data = v.we ? last_rd : v.exp_rd;
        e.err  = v.exp_err;
        e.chk  = chk;
        sb_q.push_back(e);
        mio = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; stx = v.stx;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!ready && cyc < 40);
        mio = 1'b0;
        e   = sb_q.pop_front();
        got = din;
        check({tag, " latency"}, 32'(cyc), 32'(WAITS + 2));
        if (ready) begin
            if (e.chk) check({tag, " Data_in"}, din, e.data);
`ifdef MIO_ERR_EN
            check({tag, " bus_err"}, {31'b0, err}, {31'b0, e.err});
`endif
            if (!v.we && e.chk) last_rd = e.data;
        end
        @(posedge clk); #1;
        check({tag, " ready pulse width"}, {31'b0, ready}, 32'd0);
        check({tag, " led_out"}, led, v.exp_led);
    endtask

    // Single write on the WAIT_CYCLES=0 instance
    task automatic b_write(input logic [31:0] a, input logic [31:0] d);
        int cyc;
        b_mio = 1'b1; b_we = 1'b1; b_addr = a; b_wdata = d; b_stx = STX_WORD;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!b_ready && cyc < 40);
        b_mio = 1'b0;
        check("b0 write latency", 32'(cyc), 32'd2);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] got, c1, c2;
        vec_t        v;
        exp_t        e;
        int          n_rdy, cyc, first, second;

        reset = 1'b0;
        mio = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; stx = STX_WORD;
        b_mio = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_stx = STX_WORD;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset MIO_ready", {31'b0, ready}, 32'd0);
        check("reset Data_in", din, 32'h0);
        check("reset led_out", led, 32'h0);
        check("reset b0 MIO_ready", {31'b0, b_ready}, 32'd0);
        check("reset b0 Data_in", b_din, 32'h0);
`ifdef MIO_ERR_EN
        check("reset bus_err", {31'b0, err}, 32'd0);
`endif
        reset = 1'b1;
        @(posedge clk); #1;

        //              we    addr          wdata         stx           exp_rd        exp_led       err
        tbl[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, STX_WORD,     32'h0,        32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         STX_WORD,     32'h1234_5678, 32'h0,       1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, STX_WORD,     32'h0,        32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'h0000_00AB, STX_BYTE,     32'h0,        32'h0,        1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0022, 32'hCDEF_0000, STX_HALF,     32'h0,        32'h0,        1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0020, 32'h0,         STX_WORD,     32'hCDEF_FFAB, 32'h0,       1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0024, 32'h1122_3344, STX_WORD_ALT, 32'h0,        32'h0,        1'b0};
        tbl[7]  = '{1'b1, 32'h0000_0027, 32'h9900_0000, STX_BYTE,     32'h0,        32'h0,        1'b0};
        tbl[8]  = '{1'b0, 32'h0000_0025, 32'h0,         STX_WORD,     32'h9922_3344, 32'h0,       1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0023, 32'h5566_0000, STX_HALF,     32'h0,        32'h0,        1'b0};
        tbl[10] = '{1'b0, 32'h0000_0020, 32'h0,         STX_WORD,     32'h5566_FFAB, 32'h0,       1'b0};
        tbl[11] = '{1'b1, 32'hE000_0000, 32'h1234_005A, STX_BYTE,     32'h0,        32'h1234_005A, 1'b0};
        tbl[12] = '{1'b1, 32'hE000_0000, 32'h0000_005A, STX_WORD,     32'h0,        32'h5A,       1'b0};
        tbl[13] = '{1'b1, 32'hE000_0008, 32'hCAFE_F00D, STX_WORD,     32'h0,        32'h5A,       1'b0};
        tbl[14] = '{1'b0, 32'hE000_0008, 32'h0,         STX_WORD,     32'hCAFE_F00D, 32'h5A,      1'b0};
        tbl[15] = '{1'b1, 32'hE000_000C, 32'h0000_0077, STX_WORD,     32'h0,        32'h5A,       1'b1};
        tbl[16] = '{1'b0, 32'hE000_000C, 32'h0,         STX_WORD,     32'h0,        32'h5A,       1'b1};
        tbl[17] = '{1'b0, 32'hE000_0000, 32'h0,         STX_WORD,     32'h5A,       32'h5A,       1'b0};
        tbl[18] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, STX_WORD,     32'h0,        32'h5A,       1'b0};
        tbl[19] = '{1'b1, 32'h4000_0000, 32'h0000_0123, STX_WORD,     32'h0,        32'h5A,       1'b1};
        tbl[20] = '{1'b0, 32'h4000_0000, 32'h0,         STX_WORD,     32'h0,        32'h5A,       1'b1};
        tbl[21] = '{1'b0, 32'h0000_0000, 32'h0,         STX_WORD,     32'hA5A5_A5A5, 32'h5A,      1'b0};
        tbl[22] = '{1'b0, 32'hF000_0010, 32'h0,         STX_WORD,     32'h0,        32'h5A,       1'b1};
        tbl[23] = '{1'b1, 32'h0000_0030, 32'h0BAD_F00D, STX_WORD,     32'h0,        32'h5A,       1'b0};
        tbl[24] = '{1'b0, 32'h0000_0030, 32'h0,         STX_WORD,     32'h0BAD_F00D, 32'h5A,      1'b0};

        for (int i = 0; i < 25; i++) begin
            access(tbl[i], 1'b1, $sformatf("row%0d", i), got);
        end

        // Cycle counter: one idle edge inside access plus 7 extra, plus 4
        v = '{1'b0, 32'hE000_0004, 32'h0, STX_WORD, 32'h0, 32'h5A, 1'b0};
        access(v, 1'b0, "cnt read1", c1);
        repeat (7) @(posedge clk);
        #1;
        access(v, 1'b0, "cnt read2", c2);
        check("cnt delta", c2 - c1, 32'd12);

        // Reset asserted while a write sits in WAIT
        mio = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hDEAD_BEEF; stx = STX_WORD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        mio   = 1'b0;
        #1;
        check("midrst Data_in", din, 32'h0);
        check("midrst led_out", led, 32'h0);
        n_rdy = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ready) n_rdy++;
        end
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready) n_rdy++;
        end
        check("midrst no ready", 32'(n_rdy), 32'd0);
        last_rd = 32'h0;
        v = '{1'b0, 32'h0000_0030, 32'h0, STX_WORD, 32'h0BAD_F00D, 32'h0, 1'b0};
        access(v, 1'b1, "midrst old data", got);
        v = '{1'b0, 32'hE000_0008, 32'h0, STX_WORD, 32'h0, 32'h0, 1'b0};
        access(v, 1'b1, "midrst scratch", got);

        // Back-to-back reads with zero wait states
        b_write(32'h100, 32'h1111_1111);
        b_write(32'h104, 32'h2222_2222);
        e.err = 1'b0; e.chk = 1'b1;
        e.data = 32'h1111_1111; bq.push_back(e);
        e.data = 32'h2222_2222; bq.push_back(e);
        b_mio = 1'b1; b_we = 1'b0; b_addr = 32'h100;
        cyc = 0; first = -1; second = -1;
        while (cyc < 20 && second < 0) begin
            @(posedge clk); #1; cyc++;
            if (b_ready) begin
                e = bq.pop_front();
                check("b2b Data_in", b_din, e.data);
                if (first < 0) begin
                    first  = cyc;
                    b_addr = 32'h104;
                end else begin
                    second = cyc;
                    b_mio  = 1'b0;
                end
            end
        end
        b_mio = 1'b0;
        check("b2b first latency", 32'(first), 32'd2);
        check("b2b spacing", 32'(second - first), 32'd2);
        check("b2b all responses", 32'(bq.size()), 32'd0);
        check("b0 led_out", b_led, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
